// File: rtl/ss_wbm_arb_if.sv
// Wishbone bundle between the NCH upstream DMA/SPI engines, the arbiter and the bridge master port.
// The slave modport is the arbiter's view; the master modport is the engines-plus-bridge environment.
interface ss_wbm_arb_if #(
  parameter int NCH = 4,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int SW = DW/8;

  logic [NCH-1:0]    m_cyc_i;
  logic [NCH-1:0]    m_stb_i;
  logic [NCH-1:0]    m_we_i;
  logic [NCH-1:0]    m_cab_i;
  logic [NCH*SW-1:0] m_sel_i;
  logic [NCH*AW-1:0] m_adr_i;
  logic [NCH*DW-1:0] m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [NCH-1:0]    m_ack_o;
  logic [NCH-1:0]    m_err_o;
  logic [NCH-1:0]    m_rty_o;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic              wbm_cab_o;
  logic [SW-1:0]     wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic [DW-1:0]     wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;
  logic              wbm_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/ss_wbm_arb.sv
// Round-robin N-channel Wishbone master arbiter with whole-cycle ownership (cab bursts included)
// and a stall timeout that answers err to the owner and blanks the bus until it drops cyc.
module ss_wbm_arb #(
  parameter int NCH   = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO_W = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  ss_wbm_arb_if.slave    bus,
  output logic [NCH-1:0] gnt_o,
  output logic           tmo_o
);
  localparam int SW = DW/8;
  localparam int IW = $clog2(NCH);
  localparam logic [IW:0] NCH_W = (IW+1)'(NCH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_nxt;
  logic [IW-1:0]    ptr_q, ptr_nxt;
  logic [IW-1:0]    win_q, win_nxt;
  logic [NCH-1:0]   gnt_q, gnt_nxt;
  logic [TMO_W-1:0] cnt_q, cnt_nxt;
  logic             dead_q, dead_nxt;

  logic             scan_hit;
  logic [IW-1:0]    scan_win;
  logic [IW:0]      scan_sum;
  logic             own_cyc, own_stb, own_we, own_cab;
  logic [SW-1:0]    own_sel;
  logic [AW-1:0]    own_adr;
  logic [DW-1:0]    own_dat;
  logic             busy, fire, live, term;

  // First requester strictly after the last winner, wrapping mod NCH
  always_comb begin
    scan_hit = 1'b0;
    scan_win = '0;
    scan_sum = '0;
    for (int i = 1; i <= NCH; i++) begin
      scan_sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (scan_sum >= NCH_W) scan_sum = scan_sum - NCH_W;
      if (!scan_hit && bus.m_cyc_i[scan_sum[IW-1:0]]) begin
        scan_hit = 1'b1;
        scan_win = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_cab = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    for (int k = 0; k < NCH; k++) begin
      if (win_q == IW'(k)) begin
        own_cyc = bus.m_cyc_i[k];
        own_stb = bus.m_stb_i[k];
        own_we  = bus.m_we_i[k];
        own_cab = bus.m_cab_i[k];
        own_sel = bus.m_sel_i[k*SW +: SW];
        own_adr = bus.m_adr_i[k*AW +: AW];
        own_dat = bus.m_dat_i[k*DW +: DW];
      end
    end
  end

  // dead_q holds the bus blanked after a timeout until the owner releases cyc
  assign busy = (state_q == BUSY);
  assign fire = busy && !dead_q && (&cnt_q);
  assign live = busy && !dead_q && !fire;
  assign term = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;

  assign bus.wbm_cyc_o = live & own_cyc;
  assign bus.wbm_stb_o = live & own_stb;
  assign bus.wbm_we_o  = busy & own_we;
  assign bus.wbm_cab_o = busy & own_cab;
  assign bus.wbm_sel_o = own_sel;
  assign bus.wbm_adr_o = own_adr;
  assign bus.wbm_dat_o = own_dat;

  assign bus.m_dat_o = bus.wbm_dat_i;
  assign bus.m_ack_o = live ? (gnt_q & {NCH{bus.wbm_ack_i}}) : '0;
  assign bus.m_rty_o = live ? (gnt_q & {NCH{bus.wbm_rty_i}}) : '0;
  assign bus.m_err_o = fire ? gnt_q :
                       live ? (gnt_q & {NCH{bus.wbm_err_i}}) : '0;

  assign gnt_o = gnt_q;
  assign tmo_o = fire;

  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    win_nxt   = win_q;
    gnt_nxt   = gnt_q;
    cnt_nxt   = cnt_q;
    dead_nxt  = dead_q;
    case (state_q)
      IDLE: begin
        if (scan_hit) begin
          state_nxt = BUSY;
          win_nxt   = scan_win;
          gnt_nxt   = NCH'(1) << scan_win;
          cnt_nxt   = '0;
          dead_nxt  = 1'b0;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          ptr_nxt   = win_q;
          gnt_nxt   = '0;
          dead_nxt  = 1'b0;
        end else begin
          if (fire) dead_nxt = 1'b1;
          if (term) cnt_nxt = '0;
          else if (bus.wbm_stb_o && !(&cnt_q)) cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NCH-1);
      win_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      win_q   <= win_nxt;
      gnt_q   <= gnt_nxt;
      cnt_q   <= cnt_nxt;
      dead_q  <= dead_nxt;
    end
  end
endmodule

// File: tb/tb_ss_wbm_arb.sv
// Directed scenarios plus randomized traffic for ss_wbm_arb, every cycle compared against a
// transaction-level model of owner / last winner / stall count.
module tb_ss_wbm_arb;
  localparam int NCH   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO_W = 4;
  localparam int SW    = DW/8;
  localparam int SELW  = NCH*SW;
  localparam int TMAX  = (1 << TMO_W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] gnt;
  logic           tmo;

  always #5 clk = ~clk;

  ss_wbm_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  ss_wbm_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TMO_W(TMO_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .gnt_o    (gnt),
    .tmo_o    (tmo)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus (-1 = nobody), who won last, stalled strobe cycles, timed-out flag
  int owner;
  int last;
  int stall;
  bit killed;

  logic [NCH-1:0] o_gnt, o_ack, o_err, o_rty;
  logic           o_tmo, o_cyc;
  logic [DW-1:0]  o_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    logic [NCH-1:0] eg, ea, ee, er;
    logic fire, live, ecyc, estb, ewe, ecab;
    logic term;
    #1;
    eg = '0; ea = '0; ee = '0; er = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; ecab = 1'b0;
    fire = (owner >= 0) && !killed && (stall == TMAX);
    live = (owner >= 0) && !killed && !fire;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ewe  = bus.m_we_i[owner];
      ecab = bus.m_cab_i[owner];
      if (fire) ee[owner] = 1'b1;
    end
    if (live) begin
      ecyc = bus.m_cyc_i[owner];
      estb = bus.m_stb_i[owner];
      ea[owner] = bus.wbm_ack_i;
      ee[owner] = bus.wbm_err_i;
      er[owner] = bus.wbm_rty_i;
    end
    chk("gnt", gnt, eg);
    chk("tmo", tmo, fire);
    chk("wbm_cyc", bus.wbm_cyc_o, ecyc);
    chk("wbm_stb", bus.wbm_stb_o, estb);
    chk("wbm_we", bus.wbm_we_o, ewe);
    chk("wbm_cab", bus.wbm_cab_o, ecab);
    chk("m_ack", bus.m_ack_o, ea);
    chk("m_err", bus.m_err_o, ee);
    chk("m_rty", bus.m_rty_o, er);
    chk("m_dat", bus.m_dat_o, bus.wbm_dat_i);
    if (owner >= 0) begin
      chk("wbm_adr", bus.wbm_adr_o, bus.m_adr_i[owner*AW +: AW]);
      chk("wbm_dat", bus.wbm_dat_o, bus.m_dat_i[owner*DW +: DW]);
      chk("wbm_sel", bus.wbm_sel_o, bus.m_sel_i[owner*SW +: SW]);
    end
    o_gnt = gnt; o_ack = bus.m_ack_o; o_err = bus.m_err_o; o_rty = bus.m_rty_o;
    o_tmo = tmo; o_cyc = bus.wbm_cyc_o; o_dat = bus.m_dat_o;
    term = bus.wbm_ack_i | bus.wbm_err_i | bus.wbm_rty_i;
    @(posedge clk);
    if (rst) begin
      owner = -1; last = NCH-1; stall = 0; killed = 1'b0;
    end else if (owner < 0) begin
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (last + i) % NCH;
        if (bus.m_cyc_i[c]) begin
          owner = c;
          break;
        end
      end
      if (owner >= 0) begin stall = 0; killed = 1'b0; end
    end else if (!bus.m_cyc_i[owner]) begin
      last = owner; owner = -1; killed = 1'b0;
    end else begin
      if (fire) killed = 1'b1;
      if (term) stall = 0;
      else if (estb && stall < TMAX) stall++;
    end
    #1;
  endtask

  task automatic wait_gnt(input logic [NCH-1:0] want, input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = (o_gnt == want);
    end
    chk(tag, o_gnt, want);
  endtask

  initial begin
    int order[$];
    int gstep[$];
    logic [NCH-1:0] prev;
    int acks, ch1_acks, n, rtys;
    bit fired, slow;
    int r;

    rst = 1'b1;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_cab_i = '0;
    bus.m_sel_i = '1; bus.m_adr_i = '0; bus.m_dat_i = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.m_adr_i[c*AW +: AW] = 32'h1000_0000 + 32'(c);
      bus.m_dat_i[c*DW +: DW] = 32'hA000_0000 + 32'(c);
    end
    bus.wbm_dat_i = '0; bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_rty_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    owner = -1; last = NCH-1; stall = 0; killed = 1'b0;
    step();
    chk("reset_gnt", o_gnt, 4'b0000);
    chk("reset_cyc", o_cyc, 1'b0);
    rst = 1'b0;

    // All four request at once; each takes one ack then releases
    bus.m_cyc_i = 4'b1111; bus.m_stb_i = 4'b1111; bus.wbm_ack_i = 1'b1;
    prev = '0;
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      step();
      if (o_gnt != 0 && prev == 0) begin
        order.push_back(idx_of(o_gnt));
        gstep.push_back(k);
      end
      prev = o_gnt;
      if (o_ack != 0) begin
        bus.m_cyc_i = bus.m_cyc_i & ~o_ack;
        bus.m_stb_i = bus.m_stb_i & ~o_ack;
      end
    end
    chk("t1_grants", order.size(), 4);
    if (order.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t1_order", order[i], i);
      for (int i = 1; i < 4; i++) chk("t1_gap", gstep[i] - gstep[i-1], 3);
    end
    bus.wbm_ack_i = 1'b0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
    step(); step();

    // Ch2 cab burst of 8 writes, ch1 arrives mid-burst and then reads
    bus.m_cyc_i[2] = 1'b1; bus.m_stb_i[2] = 1'b1; bus.m_cab_i[2] = 1'b1; bus.m_we_i[2] = 1'b1;
    bus.wbm_ack_i = 1'b1;
    acks = 0; ch1_acks = 0;
    for (int k = 0; k < 40 && acks < 8; k++) begin
      step();
      if (o_ack[2]) acks++;
      if (o_ack[1]) ch1_acks++;
      if (acks == 3) begin bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1; end
    end
    chk("t2_burst_acks", acks, 8);
    chk("t2_ch1_waits", ch1_acks, 0);
    bus.m_cyc_i[2] = 1'b0; bus.m_stb_i[2] = 1'b0; bus.m_cab_i[2] = 1'b0; bus.m_we_i[2] = 1'b0;
    bus.m_we_i[1] = 1'b0; bus.wbm_dat_i = 32'hDEADBEEF;
    step();
    chk("t2_drop_ack", o_ack, 4'b0100);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n++;
      if (o_gnt == 4'b0010) break;
    end
    chk("t2_ch1_delay", n, 2);
    chk("t3_read_ack", o_ack, 4'b0010);
    chk("t3_read_dat", o_dat, 32'hDEADBEEF);
    bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0; bus.wbm_ack_i = 1'b0;
    step(); step();

    // Ch3 stalls forever: timeout after TMAX stalled cycles, late ack discarded
    bus.m_cyc_i[3] = 1'b1; bus.m_stb_i[3] = 1'b1;
    n = 0; fired = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (o_tmo) begin fired = 1'b1; break; end
      if (o_gnt == 4'b1000) n++;
    end
    chk("t4_fired", fired, 1'b1);
    chk("t4_stall_cycles", n, 15);
    chk("t4_err", o_err, 4'b1000);
    chk("t4_cyc_forced", o_cyc, 1'b0);
    bus.wbm_ack_i = 1'b1;
    step();
    chk("t4_tmo_pulse", o_tmo, 1'b0);
    chk("t4_late_ack", o_ack, 4'b0000);
    chk("t4_dead_cyc", o_cyc, 1'b0);
    chk("t4_still_owned", o_gnt, 4'b1000);
    bus.wbm_ack_i = 1'b0; bus.m_cyc_i[3] = 1'b0; bus.m_stb_i[3] = 1'b0;
    step(); step();

    // Ch0: rty twice then ack, ownership held throughout
    bus.m_cyc_i[0] = 1'b1; bus.m_stb_i[0] = 1'b1;
    wait_gnt(4'b0001, "t5_gnt");
    rtys = 0;
    bus.wbm_rty_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t5_gnt_hold", o_gnt, 4'b0001);
      if (o_rty == 4'b0001) rtys++;
    end
    bus.wbm_rty_i = 1'b0; bus.wbm_ack_i = 1'b1;
    step();
    chk("t5_rty_count", rtys, 2);
    chk("t5_ack", o_ack, 4'b0001);
    chk("t5_gnt_ack", o_gnt, 4'b0001);
    bus.wbm_ack_i = 1'b0; bus.m_cyc_i[0] = 1'b0; bus.m_stb_i[0] = 1'b0;
    step(); step();

    // Reset in the middle of a ch1 burst
    bus.m_cyc_i[1] = 1'b1; bus.m_stb_i[1] = 1'b1; bus.m_cab_i[1] = 1'b1; bus.wbm_ack_i = 1'b1;
    wait_gnt(4'b0010, "t6_gnt");
    step(); step();
    rst = 1'b1;
    step();
    step();
    chk("t6_rst_gnt", o_gnt, 4'b0000);
    chk("t6_rst_cyc", o_cyc, 1'b0);
    chk("t6_rst_ack", o_ack, 4'b0000);
    rst = 1'b0;
    bus.wbm_ack_i = 1'b0; bus.m_cab_i = '0;
    bus.m_cyc_i = 4'b0011; bus.m_stb_i = 4'b0011;
    wait_gnt(4'b0001, "t6_ch0_first");
    bus.m_cyc_i = '0; bus.m_stb_i = '0;
    step(); step();

    // Randomized traffic, alternating busy bridge and near-silent bridge phases
    for (int t = 0; t < 1200; t++) begin
      slow = ((t / 200) % 2) == 1;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, slow ? 40 : 6) == 0) bus.m_cyc_i[c] = ~bus.m_cyc_i[c];
      bus.m_stb_i = bus.m_cyc_i ^ NCH'($urandom & $urandom & $urandom);
      bus.m_we_i  = NCH'($urandom);
      bus.m_cab_i = NCH'($urandom);
      bus.m_sel_i = SELW'($urandom);
      for (int c = 0; c < NCH; c++) begin
        bus.m_adr_i[c*AW +: AW] = $urandom;
        bus.m_dat_i[c*DW +: DW] = $urandom;
      end
      bus.wbm_dat_i = $urandom;
      r = int'($urandom_range(0, slow ? 99 : 9));
      bus.wbm_ack_i = slow ? (r == 0) : (r < 4);
      bus.wbm_err_i = !slow && (r == 4);
      bus.wbm_rty_i = slow ? (r == 1) : (r == 5);
      rst = ($urandom_range(0, 300) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
